cprv_ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one `cprv_ram_1p` single-port RAM instance, e.g. instruction fetch and load/store sharing one scratchpad.
- Accepts at most one access per cycle, round-robin between ports, and drives the RAM directly.
- Routes the one-cycle-latency read data back to the granted port.
- Holds each port's response in a one-entry buffer when that port applies response backpressure.

---
 rtl/cprv_ram_arbiter_if.sv | 25 ++
 rtl/cprv_ram_arbiter.sv | 109 ++++++++++
 tb/tb_cprv_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cprv_ram_arbiter_if.sv
// Requester-side bundle for one port of cprv_ram_arbiter: a request handshake
// and a response handshake with read data.
interface cprv_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/cprv_ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for one single-port RAM with per-port
// one-entry response buffers. Define CPRV_RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module cprv_ram_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cprv_ram_arbiter_if.slave     p0,
  cprv_ram_arbiter_if.slave     p1,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [1:0]            req_valid, req_we, resp_ready;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  logic [1:0]            elig, grant, infl_mine;
  logic                  gnt_sel;
  logic                  infl_v_q, infl_v_d, infl_port_q, infl_port_d;
  logic [1:0]            hold_v_q, hold_v_d;
  logic [DATA_WIDTH-1:0] hold_data_q [2];
  logic [DATA_WIDTH-1:0] hold_data_d [2];
`ifndef CPRV_RAM_ARB_FIXED_PRIO_EN
  logic                  prio_q, prio_d;
`endif

  assign req_valid    = {p1.req_valid, p0.req_valid};
  assign req_we       = {p1.req_we, p0.req_we};
  assign resp_ready   = {p1.resp_ready, p0.resp_ready};
  assign req_addr[0]  = p0.req_addr;
  assign req_addr[1]  = p1.req_addr;
  assign req_wdata[0] = p0.req_wdata;
  assign req_wdata[1] = p1.req_wdata;

  assign infl_mine = {infl_v_q & infl_port_q, infl_v_q & ~infl_port_q};

  // A port may not issue while its previous response is still unaccepted.
  assign elig = req_valid & ~hold_v_q & ~(infl_mine & ~resp_ready) & {2{~rst}};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
`ifdef CPRV_RAM_ARB_FIXED_PRIO_EN
    grant[0] = elig[0];
    grant[1] = elig[1] & ~elig[0];
`else
    prio_d = prio_q;
    if (elig == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
    else               grant = elig;
    if (grant[0])      prio_d = 1'b1;
    else if (grant[1]) prio_d = 1'b0;
`endif
  end

  assign gnt_sel     = grant[1];
  assign ram_w_en    = (|grant) & req_we[gnt_sel];
  assign ram_addr    = req_addr[gnt_sel];
  assign ram_wdata   = req_wdata[gnt_sel];
  assign infl_v_d    = |grant;
  assign infl_port_d = grant[1];

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    for (int p = 0; p < 2; p++) begin
      if (hold_v_q[p]) begin
        if (resp_ready[p]) hold_v_d[p] = 1'b0;
      end else if (infl_mine[p] && !resp_ready[p]) begin
        hold_v_d[p]    = 1'b1;
        hold_data_d[p] = ram_rdata;
      end
    end
  end

  assign p0.req_ready  = grant[0];
  assign p1.req_ready  = grant[1];
  assign p0.resp_valid = hold_v_q[0] | infl_mine[0];
  assign p1.resp_valid = hold_v_q[1] | infl_mine[1];
  assign p0.resp_rdata = hold_v_q[0] ? hold_data_q[0] : ram_rdata;
  assign p1.resp_rdata = hold_v_q[1] ? hold_data_q[1] : ram_rdata;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_v_q <= 1'b0;
      hold_v_q <= 2'b00;
`ifndef CPRV_RAM_ARB_FIXED_PRIO_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      infl_v_q <= infl_v_d;
      hold_v_q <= hold_v_d;
`ifndef CPRV_RAM_ARB_FIXED_PRIO_EN
      prio_q   <= prio_d;
`endif
    end
  end

  // NOTE: payload registers are left unreset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    infl_port_q <= infl_port_d;
    hold_data_q <= hold_data_d;
  end

endmodule

// File: tb/tb_cprv_ram_arbiter.sv
// Directed bench for cprv_ram_arbiter with a write-first, one-cycle-latency RAM model.
module tb_cprv_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 64;
`ifdef CPRV_RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_w_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [2**AW];

  int n_vec = 0;
  int n_err = 0;

  cprv_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
  cprv_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

  cprv_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .ram_w_en  (ram_w_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_w_en) begin
      mem[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = a; p0_if.req_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = a; p1_if.req_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic g, pv;
    rst = 1'b1;
    drv0(1'b1, 1'b0, 7'd0, 64'h0);
    drv1(1'b1, 1'b0, 7'd0, 64'h0);
    p0_if.resp_ready = 1'b1;
    p1_if.resp_ready = 1'b1;
    next_cycle();

    // Second reset cycle with both ports requesting: nothing may be granted.
    @(negedge clk);
    check("rst_req_ready0", p0_if.req_ready, 1'b0);
    check("rst_req_ready1", p1_if.req_ready, 1'b0);
    check("rst_resp_valid0", p0_if.resp_valid, 1'b0);
    check("rst_resp_valid1", p1_if.resp_valid, 1'b0);
    check("rst_ram_w_en", ram_w_en, 1'b0);
    next_cycle();

    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant0", p0_if.req_ready, 1'b1);
    check("post_rst_grant1", p1_if.req_ready, 1'b0);
    check("post_rst_resp_valid0", p0_if.resp_valid, 1'b0);
    next_cycle();

    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    drv1(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("first_resp_valid0", p0_if.resp_valid, 1'b1);
    check("first_resp_valid1", p1_if.resp_valid, 1'b0);
    next_cycle();

    // Preload addr 1 and 2 from port 0, addr 3 from port 1.
    drv0(1'b1, 1'b1, 7'd1, 64'h11);
    @(negedge clk);
    check("pre1_ready0", p0_if.req_ready, 1'b1);
    check("pre1_w_en", ram_w_en, 1'b1);
    check("pre1_addr", ram_addr, 7'd1);
    check("pre1_wdata", ram_wdata, 64'h11);
    next_cycle();
    drv0(1'b1, 1'b1, 7'd2, 64'h22);
    @(negedge clk);
    check("pre2_resp_valid0", p0_if.resp_valid, 1'b1);
    check("pre2_resp_rdata0", p0_if.resp_rdata, 64'h11);
    next_cycle();
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    drv1(1'b1, 1'b1, 7'd3, 64'h33);
    @(negedge clk);
    check("pre3_ready1", p1_if.req_ready, 1'b1);
    check("pre3_w_en", ram_w_en, 1'b1);
    check("pre3_resp_rdata0", p0_if.resp_rdata, 64'h22);
    next_cycle();
    drv1(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("pre4_resp_valid1", p1_if.resp_valid, 1'b1);
    check("pre4_resp_rdata1", p1_if.resp_rdata, 64'h33);
    check("pre4_resp_valid0", p0_if.resp_valid, 1'b0);
    next_cycle();

    // Same-address write then read back to back.
    drv0(1'b1, 1'b1, 7'd5, 64'hDEAD_BEEF);
    next_cycle();
    drv0(1'b1, 1'b0, 7'd5, 64'h0);
    @(negedge clk);
    check("wr_resp_valid0", p0_if.resp_valid, 1'b1);
    check("wr_resp_rdata0", p0_if.resp_rdata, 64'hDEAD_BEEF);
    check("rd_ready0", p0_if.req_ready, 1'b1);
    next_cycle();
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("rd_resp_valid0", p0_if.resp_valid, 1'b1);
    check("rd_resp_rdata0", p0_if.resp_rdata, 64'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("idle_resp_valid0", p0_if.resp_valid, 1'b0);
    next_cycle();

    // Contention: last lone grant went to port 0, so round-robin favours port 1 first.
    drv0(1'b1, 1'b0, 7'd1, 64'h0);
    drv1(1'b1, 1'b0, 7'd2, 64'h0);
    g  = FIXED ? 1'b0 : 1'b1;
    pv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rr%0d_ready0", i), p0_if.req_ready, g == 1'b0);
      check($sformatf("rr%0d_ready1", i), p1_if.req_ready, g == 1'b1);
      check($sformatf("rr%0d_addr", i), ram_addr, g ? 7'd2 : 7'd1);
      if (i > 0) begin
        check($sformatf("rr%0d_resp_valid0", i), p0_if.resp_valid, pv == 1'b0);
        check($sformatf("rr%0d_resp_valid1", i), p1_if.resp_valid, pv == 1'b1);
        check($sformatf("rr%0d_resp_rdata", i),
              pv ? p1_if.resp_rdata : p0_if.resp_rdata, pv ? 64'h22 : 64'h11);
      end
      pv = g;
      g  = FIXED ? 1'b0 : ~g;
      next_cycle();
    end
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    drv1(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("rr_tail_resp_valid0", p0_if.resp_valid, pv == 1'b0);
    check("rr_tail_resp_valid1", p1_if.resp_valid, pv == 1'b1);
    next_cycle();

    // Backpressure on port 1 while port 0 keeps issuing.
    drv1(1'b1, 1'b0, 7'd3, 64'h0);
    @(negedge clk);
    check("bp0_ready1", p1_if.req_ready, 1'b1);
    next_cycle();
    drv1(1'b1, 1'b0, 7'd2, 64'h0);
    drv0(1'b1, 1'b0, 7'd1, 64'h0);
    p1_if.resp_ready = 1'b0;
    @(negedge clk);
    check("bp1_resp_valid1", p1_if.resp_valid, 1'b1);
    check("bp1_resp_rdata1", p1_if.resp_rdata, 64'h33);
    check("bp1_ready1", p1_if.req_ready, 1'b0);
    check("bp1_ready0", p0_if.req_ready, 1'b1);
    next_cycle();
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_resp_valid1", i), p1_if.resp_valid, 1'b1);
      check($sformatf("bp%0d_resp_rdata1", i), p1_if.resp_rdata, 64'h33);
      check($sformatf("bp%0d_ready1", i), p1_if.req_ready, 1'b0);
      check($sformatf("bp%0d_ready0", i), p0_if.req_ready, 1'b1);
      check($sformatf("bp%0d_resp_rdata0", i), p0_if.resp_rdata, 64'h11);
      next_cycle();
    end
    p1_if.resp_ready = 1'b1;
    @(negedge clk);
    check("bp5_resp_valid1", p1_if.resp_valid, 1'b1);
    check("bp5_resp_rdata1", p1_if.resp_rdata, 64'h33);
    check("bp5_ready1", p1_if.req_ready, 1'b0);
    check("bp5_ready0", p0_if.req_ready, 1'b1);
    next_cycle();
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("bp6_ready1", p1_if.req_ready, 1'b1);
    check("bp6_addr", ram_addr, 7'd2);
    check("bp6_resp_valid1", p1_if.resp_valid, 1'b0);
    check("bp6_resp_valid0", p0_if.resp_valid, 1'b1);
    next_cycle();
    drv1(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("bp7_resp_valid1", p1_if.resp_valid, 1'b1);
    check("bp7_resp_rdata1", p1_if.resp_rdata, 64'h22);
    check("bp7_resp_valid0", p0_if.resp_valid, 1'b0);
    next_cycle();

    // Reset one cycle after a granted write: response lost, write stands.
    drv0(1'b1, 1'b1, 7'd7, 64'h77);
    @(negedge clk);
    check("mf_w_en", ram_w_en, 1'b1);
    next_cycle();
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mf_resp_valid0", p0_if.resp_valid, 1'b0);
    check("mf_resp_valid1", p1_if.resp_valid, 1'b0);
    next_cycle();
    drv0(1'b1, 1'b0, 7'd7, 64'h0);
    @(negedge clk);
    check("mf_rd_ready0", p0_if.req_ready, 1'b1);
    check("mf_rd_w_en", ram_w_en, 1'b0);
    next_cycle();
    drv0(1'b0, 1'b0, 7'd0, 64'h0);
    @(negedge clk);
    check("mf_rd_resp_valid0", p0_if.resp_valid, 1'b1);
    check("mf_rd_resp_rdata0", p0_if.resp_rdata, 64'h77);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
